// File: rtl/traffic_intersection_ctrl_pkg.sv
// Shared types and width helpers for the intersection signal controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2,
    FLASH   = 2'd3
  } state_e;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Counter width for a state duration; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_rr_next_sel.sv
// Round-robin successor search: first requesting approach after active_idx,
// wrapping; also reports whether any approach other than the masked one requests.
module rr_next_sel
  import traffic_pkg::*;
#(
  parameter int unsigned N_DIR = 4,
  parameter int unsigned IDX_W = $clog2(N_DIR)
) (
  input  logic [N_DIR-1:0] req,
  input  logic [IDX_W-1:0] active_idx,
  input  logic             mask_self,
  output logic [IDX_W-1:0] next_idx,
  output logic             any_other
);

  logic [N_DIR-1:0] cand;

  function automatic int unsigned wrap_idx(input int unsigned base, input int unsigned off);
    return (base + off) % N_DIR;
  endfunction

  always_comb begin
    cand = req;
    if (mask_self) cand[active_idx] = 1'b0;
    any_other = |cand;
    // Fixed rotation when nobody requests; otherwise the smallest offset wins
    // because the scan runs from the farthest offset down to the nearest.
    next_idx = IDX_W'(wrap_idx(int'(active_idx), 1));
    for (int unsigned off = N_DIR; off >= 1; off--) begin
      if (cand[wrap_idx(int'(active_idx), off)]) next_idx = IDX_W'(wrap_idx(int'(active_idx), off));
    end
  end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// N-approach intersection controller: request-driven round robin with gap-out,
// rest-in-green, all-red clearance and flashing-yellow night mode.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned N_DIR             = 4,
  parameter int unsigned GREEN_CYCLES      = 20,
  parameter int unsigned MIN_GREEN_CYCLES  = 5,
  parameter int unsigned YELLOW_CYCLES     = 3,
  parameter int unsigned ALL_RED_CYCLES    = 2,
  parameter int unsigned FLASH_HALF_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_DIR-1:0]         req,
  input  logic                     flash_en,
  output logic [N_DIR-1:0]         red,
  output logic [N_DIR-1:0]         yellow,
  output logic [N_DIR-1:0]         green,
  output logic [$clog2(N_DIR)-1:0] active_idx,
  output logic                     phase_start,
  output logic                     flashing
);

  localparam int unsigned IDX_W = $clog2(N_DIR);
  localparam int unsigned CNT_W = cnt_width(max4(GREEN_CYCLES, YELLOW_CYCLES,
                                                 ALL_RED_CYCLES, FLASH_HALF_CYCLES));

  localparam logic [CNT_W-1:0] G_LAST   = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALL_RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] F_LAST   = CNT_W'(FLASH_HALF_CYCLES - 1);

  if (N_DIR < 2) begin : g_bad_n_dir
    $error("traffic_intersection_ctrl: N_DIR must be >= 2");
  end
  if (MIN_GREEN_CYCLES < 1 || GREEN_CYCLES < MIN_GREEN_CYCLES) begin : g_bad_green
    $error("traffic_intersection_ctrl: need 1 <= MIN_GREEN_CYCLES <= GREEN_CYCLES");
  end
  if (YELLOW_CYCLES < 1 || ALL_RED_CYCLES < 1 || FLASH_HALF_CYCLES < 1) begin : g_bad_dur
    $error("traffic_intersection_ctrl: yellow, all-red and flash durations must be >= 1");
  end

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] idx_n;
  logic             flash_on, flash_on_n;
  logic [IDX_W-1:0] sel_idx;
  logic             other_req;

  rr_next_sel #(
    .N_DIR (N_DIR),
    .IDX_W (IDX_W)
  ) u_sel (
    .req        (req),
    .active_idx (active_idx),
    .mask_self  (state == GREEN),
    .next_idx   (sel_idx),
    .any_other  (other_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ALL_RED;
      cnt        <= '0;
      active_idx <= IDX_W'(N_DIR - 1);
      flash_on   <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      active_idx <= idx_n;
      flash_on   <= flash_on_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt + CNT_W'(1);
    idx_n      = active_idx;
    flash_on_n = flash_on;
    case (state)
      ALL_RED: begin
        if (cnt == AR_LAST) begin
          cnt_n = '0;
          if (flash_en) begin
            state_n    = FLASH;
            flash_on_n = 1'b1;
          end else begin
            state_n = GREEN;
            idx_n   = sel_idx;
          end
        end
      end
      GREEN: begin
        if (flash_en ||
            (cnt >= MIN_LAST && other_req && (!req[active_idx] || cnt >= G_LAST))) begin
          state_n = YELLOW;
          cnt_n   = '0;
        end else if (cnt >= G_LAST) begin
          cnt_n = G_LAST;
        end
      end
      YELLOW: begin
        if (cnt == Y_LAST) begin
          state_n = ALL_RED;
          cnt_n   = '0;
        end
      end
      FLASH: begin
        if (!flash_en) begin
          state_n = ALL_RED;
          cnt_n   = '0;
        end else if (cnt == F_LAST) begin
          cnt_n      = '0;
          flash_on_n = ~flash_on;
        end
      end
      default: begin
        state_n = ALL_RED;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    red         = '1;
    yellow      = '0;
    green       = '0;
    phase_start = 1'b0;
    flashing    = 1'b0;
    case (state)
      GREEN: begin
        red[active_idx]   = 1'b0;
        green[active_idx] = 1'b1;
        phase_start       = (cnt == '0);
      end
      YELLOW: begin
        red[active_idx]    = 1'b0;
        yellow[active_idx] = 1'b1;
      end
      FLASH: begin
        red      = '0;
        yellow   = {N_DIR{flash_on}};
        flashing = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Scenario bench for traffic_intersection_ctrl against a time-based reference model.
module tb_traffic_intersection_ctrl;

  localparam int N   = 4;
  localparam int G   = 20;
  localparam int MIN = 5;
  localparam int Y   = 3;
  localparam int AR  = 2;
  localparam int H   = 4;
  localparam int IW  = 2;
  localparam int OW  = 3 * N + IW + 2;

  localparam int M_CLR = 0, M_GRN = 1, M_YEL = 2, M_FLS = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic          flash_en = 1'b0;
  logic [N-1:0]  red, yellow, green;
  logic [IW-1:0] active_idx;
  logic          phase_start, flashing;

  int asserts = 0;
  int fails   = 0;
  int cyc     = 0;

  int m_mode = M_CLR;
  int m_t    = 0;
  int m_idx  = N - 1;
  logic [OW-1:0] exp_v = '0;
  wire  [OW-1:0] obs = {red, yellow, green, active_idx, phase_start, flashing};

  logic inv_en = 1'b0;

  traffic_intersection_ctrl #(
    .N_DIR             (N),
    .GREEN_CYCLES      (G),
    .MIN_GREEN_CYCLES  (MIN),
    .YELLOW_CYCLES     (Y),
    .ALL_RED_CYCLES    (AR),
    .FLASH_HALF_CYCLES (H)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .flash_en    (flash_en),
    .red         (red),
    .yellow      (yellow),
    .green       (green),
    .active_idx  (active_idx),
    .phase_start (phase_start),
    .flashing    (flashing)
  );

  always #5 clk = ~clk;

  // Reference model: elapsed time in the current interval, unbounded in green.
  task automatic tick();
    logic [N-1:0] er, ey, eg;
    int others;
    int pick;
    @(posedge clk);
    if (rst) begin
      m_mode = M_CLR; m_t = 0; m_idx = N - 1;
    end else begin
      case (m_mode)
        M_CLR: begin
          if (m_t == AR - 1) begin
            m_t = 0;
            if (flash_en) m_mode = M_FLS;
            else begin
              pick = (m_idx + 1) % N;
              for (int k = N; k >= 1; k--) if (req[(m_idx + k) % N]) pick = (m_idx + k) % N;
              m_idx = pick;
              m_mode = M_GRN;
            end
          end else m_t++;
        end
        M_GRN: begin
          others = 0;
          for (int k = 0; k < N; k++) if (k != m_idx && req[k]) others = 1;
          if (flash_en || (m_t >= MIN - 1 && others == 1 && (!req[m_idx] || m_t >= G - 1))) begin
            m_mode = M_YEL; m_t = 0;
          end else m_t++;
        end
        M_YEL: begin
          if (m_t == Y - 1) begin m_mode = M_CLR; m_t = 0; end
          else m_t++;
        end
        default: begin
          if (!flash_en) begin m_mode = M_CLR; m_t = 0; end
          else m_t++;
        end
      endcase
    end
    er = '1; ey = '0; eg = '0;
    if (m_mode == M_GRN) begin er[m_idx] = 1'b0; eg[m_idx] = 1'b1; end
    if (m_mode == M_YEL) begin er[m_idx] = 1'b0; ey[m_idx] = 1'b1; end
    if (m_mode == M_FLS) begin er = '0; ey = (((m_t / H) % 2) == 0) ? '1 : '0; end
    exp_v = {er, ey, eg, IW'(m_idx), (m_mode == M_GRN && m_t == 0), (m_mode == M_FLS)};
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    inv_en = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Lamp invariants, sampled mid-cycle.
  logic          y_since = 1'b1;
  logic [N-1:0]  p_green = '0, p_red = '1;
  logic          p_flash = 1'b0;
  always @(negedge clk) begin
    if (inv_en) begin
      int lit_bad, nonred;
      if (rst) y_since = 1'b1;
      if (!flashing) begin
        lit_bad = 0; nonred = 0;
        for (int i = 0; i < N; i++) begin
          if ((int'(red[i]) + int'(yellow[i]) + int'(green[i])) != 1) lit_bad++;
          if (!red[i]) nonred++;
        end
        asserts++;
        if (lit_bad != 0) begin
          fails++;
          $display("FAIL inv_one_lamp t=%0t red=%b yellow=%b green=%b required one lamp each", $time, red, yellow, green);
        end
        asserts++;
        if (nonred > 1) begin
          fails++;
          $display("FAIL inv_one_nonred t=%0t red=%b required at most one zero", $time, red);
        end
        if (yellow != '0) y_since = 1'b1;
      end
      if (green != '0 && p_green == '0) begin
        asserts++;
        if (!(p_red == '1 && !p_flash && y_since)) begin
          fails++;
          $display("FAIL inv_green_entry t=%0t prev_red=%b prev_flash=%b yellow_seen=%b required 1111/0/1", $time, p_red, p_flash, y_since);
        end
        y_since = 1'b0;
      end
      p_green = green; p_red = red; p_flash = flashing;
    end
  end

  task automatic test_reset();
    req = '0; flash_en = 1'b0;
    do_reset();
    asserts++; if (red !== 4'b1111) begin fails++; $display("FAIL reset_red got=%b exp=1111", red); end
    asserts++; if (yellow !== 4'b0000) begin fails++; $display("FAIL reset_yellow got=%b exp=0000", yellow); end
    asserts++; if (green !== 4'b0000) begin fails++; $display("FAIL reset_green got=%b exp=0000", green); end
    asserts++; if (active_idx !== 2'd3) begin fails++; $display("FAIL reset_idx got=%0d exp=3", active_idx); end
    asserts++; if ({phase_start, flashing} !== 2'b00) begin fails++; $display("FAIL reset_flags got=%b exp=00", {phase_start, flashing}); end
    asserts++; if (obs !== exp_v) begin fails++; $display("FAIL reset_model got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_round_robin();
    int starts[$];
    int idxs[$];
    req = 4'b1111; flash_en = 1'b0;
    do_reset();
    for (int c = 1; c <= 102; c++) begin
      tick();
      asserts++; if (obs !== exp_v) begin fails++; $display("FAIL rr_model c=%0d got=%h exp=%h", c, obs, exp_v); end
      if (phase_start) begin starts.push_back(c); idxs.push_back(int'(active_idx)); end
    end
    asserts++;
    if (starts.size() != 5) begin fails++; $display("FAIL rr_green_count got=%0d exp=5", starts.size()); end
    for (int k = 0; k < 5 && k < starts.size(); k++) begin
      asserts++;
      if (starts[k] != 2 + 25 * k || idxs[k] != k % 4) begin
        fails++;
        $display("FAIL rr_start k=%0d got c=%0d idx=%0d exp c=%0d idx=%0d", k, starts[k], idxs[k], 2 + 25 * k, k % 4);
      end
    end
  endtask

  task automatic test_rest_in_green();
    bit found = 0;
    req = 4'b1000; flash_en = 1'b0;
    do_reset();
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (phase_start) found = 1;
    end
    asserts++; if (!found) begin fails++; $display("FAIL rest_timeout got=no_green exp=green"); end
    asserts++; if (active_idx !== 2'd3) begin fails++; $display("FAIL rest_first_idx got=%0d exp=3", active_idx); end
    for (int g = 1; g <= 30; g++) begin
      tick();
      asserts++; if (obs !== exp_v) begin fails++; $display("FAIL rest_model g=%0d got=%h exp=%h", g, obs, exp_v); end
      if (g == 25) begin
        asserts++; if (green !== 4'b1000) begin fails++; $display("FAIL rest_hold got=%b exp=1000", green); end
      end
    end
    req = 4'b1010;
    tick();
    asserts++; if (yellow !== 4'b1000) begin fails++; $display("FAIL rest_yellow got=%b exp=1000", yellow); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      asserts++; if (obs !== exp_v) begin fails++; $display("FAIL rest_clear_model k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
    tick();
    asserts++; if ({green, phase_start} !== 5'b0010_1) begin fails++; $display("FAIL rest_next_green got=%b exp=00101", {green, phase_start}); end
  endtask

  task automatic test_gap_out();
    bit found = 0;
    req = 4'b0101; flash_en = 1'b0;
    do_reset();
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (phase_start) found = 1;
    end
    asserts++; if (!found || active_idx !== 2'd0) begin fails++; $display("FAIL gap_first got found=%0d idx=%0d exp 1/0", found, active_idx); end
    tick(); tick();
    req = 4'b0100;
    tick(); tick();
    asserts++; if (green !== 4'b0001) begin fails++; $display("FAIL gap_min_hold got=%b exp=0001", green); end
    tick();
    asserts++; if (yellow !== 4'b0001) begin fails++; $display("FAIL gap_yellow got=%b exp=0001", yellow); end
    for (int g = 6; g <= 9; g++) begin
      tick();
      asserts++; if (obs !== exp_v) begin fails++; $display("FAIL gap_model g=%0d got=%h exp=%h", g, obs, exp_v); end
    end
    tick();
    asserts++; if (green !== 4'b0100) begin fails++; $display("FAIL gap_next_green got=%b exp=0100", green); end
  endtask

  task automatic test_flash();
    bit found = 0;
    logic [N-1:0] ey;
    req = 4'b1111; flash_en = 1'b0;
    do_reset();
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (phase_start) found = 1;
    end
    asserts++; if (!found) begin fails++; $display("FAIL flash_timeout got=no_green exp=green"); end
    for (int g = 1; g <= 7; g++) tick();
    flash_en = 1'b1;
    tick();
    asserts++; if (yellow !== 4'b0001) begin fails++; $display("FAIL flash_yellow_entry got=%b exp=0001", yellow); end
    for (int t = 2; t <= 5; t++) begin
      tick();
      asserts++; if (obs !== exp_v) begin fails++; $display("FAIL flash_pre_model t=%0d got=%h exp=%h", t, obs, exp_v); end
    end
    for (int t = 6; t <= 21; t++) begin
      tick();
      ey = (((t - 6) / H) % 2 == 0) ? 4'b1111 : 4'b0000;
      asserts++;
      if ({red, green, yellow, flashing} !== {4'b0000, 4'b0000, ey, 1'b1}) begin
        fails++;
        $display("FAIL flash_pattern t=%0d got r=%b g=%b y=%b f=%b exp r=0000 g=0000 y=%b f=1", t, red, green, yellow, flashing, ey);
      end
    end
    flash_en = 1'b0;
    tick();
    asserts++; if ({red, flashing} !== 5'b1111_0) begin fails++; $display("FAIL flash_exit got=%b exp=11110", {red, flashing}); end
    tick();
    tick();
    asserts++; if (green !== 4'b0010) begin fails++; $display("FAIL flash_resume_green got=%b exp=0010", green); end
  endtask

  task automatic test_reset_mid_yellow();
    bit found = 0;
    req = 4'b1111; flash_en = 1'b0;
    do_reset();
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (yellow != '0) found = 1;
    end
    asserts++; if (!found) begin fails++; $display("FAIL mid_yellow_timeout got=no_yellow exp=yellow"); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    asserts++;
    if ({red, yellow, active_idx} !== {4'b1111, 4'b0000, 2'd3}) begin
      fails++;
      $display("FAIL mid_yellow_reset got r=%b y=%b idx=%0d exp r=1111 y=0000 idx=3", red, yellow, active_idx);
    end
    tick();
    tick();
    asserts++; if (green !== 4'b0001) begin fails++; $display("FAIL mid_yellow_regreen got=%b exp=0001", green); end
  endtask

  task automatic test_no_req();
    int ps_cnt = 0;
    bit yel = 0;
    req = '0; flash_en = 1'b0;
    do_reset();
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (phase_start) ps_cnt++;
      if (yellow != '0) yel = 1;
      if (c == 2) begin
        asserts++; if (green !== 4'b0001) begin fails++; $display("FAIL noreq_green got=%b exp=0001", green); end
      end
    end
    asserts++; if (ps_cnt != 1) begin fails++; $display("FAIL noreq_phase_start got=%0d exp=1", ps_cnt); end
    asserts++; if (yel) begin fails++; $display("FAIL noreq_yellow got=seen exp=none"); end
    asserts++; if (obs !== exp_v) begin fails++; $display("FAIL noreq_model got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_random();
    req = N'($urandom); flash_en = 1'b0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      if ($urandom_range(0, 119) == 0) flash_en = ~flash_en;
      tick();
      asserts++; if (obs !== exp_v) begin fails++; $display("FAIL random_model c=%0d got=%h exp=%h", c, obs, exp_v); end
    end
    flash_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_rest_in_green();
    test_gap_out();
    test_flash();
    test_reset_mid_yellow();
    test_no_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
